crossbar_ingress_ctrl: RTL and testbench
========================================

# crossbar_ingress_ctrl

Ingress controller directly upstream of the 2x2 crossbar (`in1`, `in2`, `select` → `out1`, `out2`). It accepts two source channels, each sending bursts tagged with a destination output. It resolves output conflicts with round-robin arbitration and locks `select` for the duration of each burst. It also registers the data onto the crossbar inputs, with per-output valids.

## Interface
- `DATA_W`, default 1: width of each data lane; matches crossbar lane width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s0_valid`, `s1_valid`  in  1  source beat valid.
- `s0_dest`, `s1_dest`  in  1  destination: 0 = crossbar `out1`, 1 = crossbar `out2`; sampled at arbitration, must stay constant within a burst.
- `s0_last`, `s1_last`  in  1  final beat of burst.
- `s0_data`, `s1_data`  in  DATA_W  beat payload.
- `s0_ready`, `s1_ready`  out  1  beat accepted when valid & ready; registered.
- `xb_in1`, `xb_in2`  out  DATA_W  to crossbar `in1` (from s0) and `in2` (from s1).
- `xb_select`  out  1  0 = straight (in1→out1, in2→out2), 1 = cross (in1→out2, in2→out1).
- `out1_valid`, `out2_valid`  out  1  crossbar output carries a valid beat this cycle.

## Operation
- Required select per source: s0 needs `select = s0_dest`; s1 needs `select = ~s1_dest`. Compatible iff `s0_dest != s1_dest`.
- Round-robin pointer `rr`: 0 favours s0, 1 favours s1.
- FSM states:
  - IDLE: both ready low.
    - No valid: stay in IDLE.
    - One valid: grant that source, go to BUSY.
    - Both valid and compatible: grant both, select = `s0_dest`, go to BUSY; `rr` unchanged.
    - Both valid and in conflict: grant `rr` winner only, go to BUSY; `rr` flips to the loser.
  - BUSY: `xb_select` is frozen.
    - Granted sources have ready = 1 and stay granted until their `last` beat is accepted; that source's ready drops on the next cycle.
    - Return to IDLE when every granted source has released.
    - A non-granted source never joins mid-BUSY, even if compatible.
- Granted source with valid low: no transfer, ready held, burst continues.
- `xb_select` is updated only on the IDLE→BUSY transition; otherwise it holds its last value.
- `xb_inN`: registered data of the accepted beat; 0 in any cycle with no beat from that source.
- `outK_valid`: 1 the cycle after a beat from the source mapped to output K under the current `xb_select` is accepted.
- Reset (any time, including mid-burst):
  - State IDLE, `rr` = 0.
  - All outputs 0: ready, `xb_in*`, `xb_select`, `out*_valid`.
  - In-flight bursts are abandoned; sources restart after reset.

## Timing
- Arbitration latency: valid sampled in IDLE at edge N; ready high from N+1; first beat accepted at edge N+1 at the earliest.
- Data latency: beat accepted at edge M appears on `xb_in*` / `out*_valid` during cycle M+1 (1 cycle).
- Burst end: `last` accepted at edge M → that ready low from M+1. If it was the final granted source, state is IDLE at M+1 and the next grant is ready at M+2 (one bubble cycle per burst).
- Single-beat burst (`last` on first beat) is legal.
- No combinational path from any input to any output.

## Structure
- Package `crossbar_pkg`:
  - FSM state encoding (IDLE, BUSY).
  - `SEL_STRAIGHT` = 0, `SEL_CROSS` = 1.
  - Destination constants `DEST_OUT1` = 0, `DEST_OUT2` = 1.
- Sub-module `rr_arb2`:
  - Two-request round-robin arbiter, with inputs `req[1:0]`, `update` and outputs `gnt[1:0]`, pointer state.
  - Instanced once; the conflict/compatibility decode stays in the top module.

## Test plan
- Reset mid-burst: s0 granted and mid-burst, `rst_n` pulsed low → all outputs 0 asynchronously; after release, new s0 burst is granted with N+1 latency.
- Compatible pair: s0 dest 0 data 1, s1 dest 1 data 0, 3-beat bursts → `xb_select` = 0, both readies high together, `out1_valid` = `out2_valid` = 1 for 3 cycles, `xb_in1` = 1, `xb_in2` = 0.
- Cross pair: s0 dest 1, s1 dest 0 → `xb_select` = 1, s0 data appears as `xb_in1` routed to `out2_valid`.
- Conflict: both dest 0, `rr` = 0, 2-beat bursts → s0 served first with `xb_select` = 0; after one bubble, s1 served with `xb_select` = 1; `rr` ends at 1. Repeat the conflict → s1 is granted first this time, `rr` ends at 0.
- Gap and single-beat: granted s1 drops valid for 2 cycles mid-burst → ready stays 1 and `out*_valid` is 0 in those cycles. Then a single-beat burst → ready high for exactly 1 cycle, state IDLE on the next cycle.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar ingress controller.
package crossbar_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_CROSS    = 1'b1;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  // Select value a source needs to reach its destination.
  // s0 drives in1, so it needs select == dest; s1 drives in2, so it needs ~dest.
  function automatic logic sel_for(input logic src, input logic dest);
    return src ? ~dest : dest;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; pointer 0 favours req[0], 1 favours req[1].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic r_ptr;

  // Grant the single requester, or the favoured one when both ask.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
  end

  // On a contested grant the pointer moves to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_ptr <= 1'b0;
    else if (update && req == 2'b11)  r_ptr <= ~r_ptr;
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/crossbar_ingress_ctrl.sv
// Ingress controller for a 2x2 crossbar: burst arbitration, select locking,
// and registered data/valid onto the crossbar inputs.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no grant held; sample valids and arbitrate
//  ST_BUSY | select frozen; granted sources transfer until their last beat
module crossbar_ingress_ctrl
  import crossbar_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic              s0_dest,
  input  logic              s0_last,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  input  logic              s1_dest,
  input  logic              s1_last,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s0_ready,
  output logic              s1_ready,
  output logic [DATA_W-1:0] xb_in1,
  output logic [DATA_W-1:0] xb_in2,
  output logic              xb_select,
  output logic              out1_valid,
  output logic              out2_valid
);

  state_e            r_state;
  logic              r_s0_ready;
  logic              r_s1_ready;
  logic              r_sel;
  logic [DATA_W-1:0] r_xb_in1;
  logic [DATA_W-1:0] r_xb_in2;
  logic              r_out1_valid;
  logic              r_out2_valid;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_rr;
  logic       w_both;
  logic       w_compat;
  logic       w_arb_update;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_rel0;
  logic       w_rel1;
  logic       w_hold0;
  logic       w_hold1;

  assign w_req        = {s1_valid, s0_valid};
  assign w_both       = s0_valid & s1_valid;
  assign w_compat     = (s0_dest != s1_dest);
  assign w_arb_update = (r_state == ST_IDLE) & w_both & ~w_compat;

  assign w_acc0  = r_s0_ready & s0_valid;
  assign w_acc1  = r_s1_ready & s1_valid;
  assign w_rel0  = w_acc0 & s0_last;
  assign w_rel1  = w_acc1 & s1_last;
  assign w_hold0 = r_s0_ready & ~w_rel0;
  assign w_hold1 = r_s1_ready & ~w_rel1;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .update (w_arb_update),
    .gnt    (w_gnt),
    .ptr    (w_rr)
  );

  // Grant FSM: picks sources and select in IDLE, releases grants on last beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_s0_ready <= 1'b0;
      r_s1_ready <= 1'b0;
      r_sel      <= SEL_STRAIGHT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state <= ST_BUSY;
            if (w_both && w_compat) begin
              r_s0_ready <= 1'b1;
              r_s1_ready <= 1'b1;
              r_sel      <= sel_for(1'b0, s0_dest);
            end else if (w_both) begin
              r_s0_ready <= w_gnt[0];
              r_s1_ready <= w_gnt[1];
              r_sel      <= w_rr ? sel_for(1'b1, s1_dest) : sel_for(1'b0, s0_dest);
            end else begin
              r_s0_ready <= w_gnt[0];
              r_s1_ready <= w_gnt[1];
              r_sel      <= s0_valid ? sel_for(1'b0, s0_dest) : sel_for(1'b1, s1_dest);
            end
          end
        end
        ST_BUSY: begin
          if (w_rel0) r_s0_ready <= 1'b0;
          if (w_rel1) r_s1_ready <= 1'b0;
          if (!w_hold0 && !w_hold1) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register accepted beats onto the crossbar lanes with per-output valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xb_in1     <= '0;
      r_xb_in2     <= '0;
      r_out1_valid <= 1'b0;
      r_out2_valid <= 1'b0;
    end else begin
      r_xb_in1     <= w_acc0 ? s0_data : '0;
      r_xb_in2     <= w_acc1 ? s1_data : '0;
      r_out1_valid <= (r_sel == SEL_CROSS) ? w_acc1 : w_acc0;
      r_out2_valid <= (r_sel == SEL_CROSS) ? w_acc0 : w_acc1;
    end
  end

  assign s0_ready   = r_s0_ready;
  assign s1_ready   = r_s1_ready;
  assign xb_in1     = r_xb_in1;
  assign xb_in2     = r_xb_in2;
  assign xb_select  = r_sel;
  assign out1_valid = r_out1_valid;
  assign out2_valid = r_out2_valid;

endmodule

// File: tb/tb_crossbar_ingress_ctrl.sv
// Self-checking bench for crossbar_ingress_ctrl: a cycle model of the
// arbitration rules checked every cycle, plus literal scenario expectations.
module tb_crossbar_ingress_ctrl;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s0_dest, s0_last;
  logic          s1_valid, s1_dest, s1_last;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready, xb_select, out1_valid, out2_valid;
  logic [DW-1:0] xb_in1, xb_in2;

  int total = 0;
  int bad   = 0;

  crossbar_ingress_ctrl #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_dest(s0_dest), .s0_last(s0_last), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_dest(s1_dest), .s1_last(s1_last), .s1_data(s1_data),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .xb_in1(xb_in1), .xb_in2(xb_in2), .xb_select(xb_select),
    .out1_valid(out1_valid), .out2_valid(out2_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle following each edge, derived from the
  // burst rules: who holds a grant, which output each source lands on.
  logic          e_rdy0, e_rdy1, e_sel, e_o1v, e_o2v;
  logic [DW-1:0] e_in1, e_in2;
  bit            m_busy, m_rr, m_a0, m_a1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rdy0 = 0; e_rdy1 = 0; e_sel = 0; e_o1v = 0; e_o2v = 0;
      e_in1 = '0; e_in2 = '0; m_busy = 0; m_rr = 0;
    end else begin
      m_a0 = e_rdy0 && s0_valid;
      m_a1 = e_rdy1 && s1_valid;
      e_in1 = m_a0 ? s0_data : '0;
      e_in2 = m_a1 ? s1_data : '0;
      // straight: s0->out1, s1->out2; cross swaps them
      e_o1v = e_sel ? m_a1 : m_a0;
      e_o2v = e_sel ? m_a0 : m_a1;
      if (m_busy) begin
        if (m_a0 && s0_last) e_rdy0 = 0;
        if (m_a1 && s1_last) e_rdy1 = 0;
        m_busy = e_rdy0 || e_rdy1;
      end else if (s0_valid && s1_valid) begin
        m_busy = 1;
        if (s0_dest != s1_dest) begin
          e_rdy0 = 1; e_rdy1 = 1; e_sel = s0_dest;
        end else if (!m_rr) begin
          e_rdy0 = 1; e_sel = s0_dest; m_rr = 1;
        end else begin
          e_rdy1 = 1; e_sel = !s1_dest; m_rr = 0;
        end
      end else if (s0_valid) begin
        m_busy = 1; e_rdy0 = 1; e_sel = s0_dest;
      end else if (s1_valid) begin
        m_busy = 1; e_rdy1 = 1; e_sel = !s1_dest;
      end
    end
  end

  // ---------------- compare + scenario monitor ----------------
  int negcnt = 0;
  int n_r0, n_r1, n_o1, n_o2, n_both, first_src;
  int first_r0, first_r1, last_r0, last_r1;
  logic sel_r0, sel_r1;
  logic [DW-1:0] in1_both, in2_both, in1_o2;
  int t_start [2];

  task automatic clear_mon();
    n_r0 = 0; n_r1 = 0; n_o1 = 0; n_o2 = 0; n_both = 0; first_src = -1;
    first_r0 = -1; first_r1 = -1; last_r0 = -1; last_r1 = -1;
    sel_r0 = 1'bx; sel_r1 = 1'bx; in1_both = 'x; in2_both = 'x; in1_o2 = 'x;
  endtask

  always @(negedge clk) begin
    negcnt++;
    chk("s0_ready",   s0_ready,   e_rdy0);
    chk("s1_ready",   s1_ready,   e_rdy1);
    chk("xb_select",  xb_select,  e_sel);
    chk("xb_in1",     xb_in1,     e_in1);
    chk("xb_in2",     xb_in2,     e_in2);
    chk("out1_valid", out1_valid, e_o1v);
    chk("out2_valid", out2_valid, e_o2v);
    if (first_src < 0 && (s0_ready || s1_ready))
      first_src = (s0_ready && s1_ready) ? 2 : (s0_ready ? 0 : 1);
    if (s0_ready) begin
      n_r0++; last_r0 = negcnt;
      if (first_r0 < 0) begin first_r0 = negcnt; sel_r0 = xb_select; end
    end
    if (s1_ready) begin
      n_r1++; last_r1 = negcnt;
      if (first_r1 < 0) begin first_r1 = negcnt; sel_r1 = xb_select; end
    end
    if (out1_valid) n_o1++;
    if (out2_valid) begin n_o2++; in1_o2 = xb_in1; end
    if (out1_valid && out2_valid) begin n_both++; in1_both = xb_in1; in2_both = xb_in2; end
  end

  // ---------------- stimulus ----------------
  task automatic set_src(input int src, input logic v, input logic d,
                         input logic [DW-1:0] dat, input logic l);
    if (src == 0) begin s0_valid = v; s0_dest = d; s0_data = dat; s0_last = l; end
    else          begin s1_valid = v; s1_dest = d; s1_data = dat; s1_last = l; end
  endtask

  // Send an n-beat burst; beat i carries base + i*inc. Optionally drop valid
  // for gap_len cycles once gap_after beats have been accepted.
  task automatic send(input int src, input logic dest, input int n,
                      input logic [DW-1:0] base, input int inc,
                      input int gap_after, input int gap_len);
    int i = 0, g = 0, cyc = 0;
    bit started = 0;
    while (i < n) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL send_timeout src%0d: got %0d beats expected %0d", src, i, n);
        break;
      end
      if (i == gap_after && g < gap_len) begin
        set_src(src, 1'b0, dest, '0, 1'b0);
        g++;
        continue;
      end
      set_src(src, 1'b1, dest, base + DW'(i * inc), (i == n - 1));
      if (!started) begin t_start[src] = negcnt; started = 1; end
      if ((src == 0) ? s0_ready : s1_ready) i++;
    end
    @(negedge clk); #1;
    set_src(src, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    set_src(0, 0, 0, '0, 0);
    set_src(1, 0, 0, '0, 0);
    clear_mon();
    #1 rst_n = 1'b0;
    #7;
    chk("rst_ready0", s0_ready, 0);
    chk("rst_select", xb_select, 0);
    chk("rst_o1v", out1_valid, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Reset mid-burst
    @(negedge clk); #1;
    set_src(0, 1'b1, 1'b0, 4'h5, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_ready0", s0_ready, 1);
    chk("pre_rst_in1", xb_in1, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready0", s0_ready, 0);
    chk("arst_in1", xb_in1, 0);
    chk("arst_o1v", out1_valid, 0);
    chk("arst_select", xb_select, 0);
    set_src(0, 0, 0, '0, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    clear_mon();
    send(0, 1'b0, 2, 4'h3, 1, -1, 0);
    settle();
    chk("post_rst_latency", first_r0 - t_start[0], 1);
    chk("post_rst_beats", n_o1, 2);

    // Compatible pair, straight
    clear_mon();
    fork
      send(0, 1'b0, 3, 4'h1, 0, -1, 0);
      send(1, 1'b1, 3, 4'h0, 0, -1, 0);
    join
    settle();
    chk("compat_first", first_src, 2);
    chk("compat_sel", sel_r0, 0);
    chk("compat_both", n_both, 3);
    chk("compat_in1", in1_both, 4'h1);
    chk("compat_in2", in2_both, 4'h0);

    // Cross pair
    clear_mon();
    fork
      send(0, 1'b1, 2, 4'hA, 0, -1, 0);
      send(1, 1'b0, 2, 4'h5, 0, -1, 0);
    join
    settle();
    chk("cross_sel", sel_r0, 1);
    chk("cross_o2", n_o2, 2);
    chk("cross_o1", n_o1, 2);
    chk("cross_in1_on_out2", in1_o2, 4'hA);

    // Conflict, rr starts at 0
    clear_mon();
    fork
      send(0, 1'b0, 2, 4'h6, 1, -1, 0);
      send(1, 1'b0, 2, 4'h9, 1, -1, 0);
    join
    settle();
    chk("conf1_first", first_src, 0);
    chk("conf1_sel0", sel_r0, 0);
    chk("conf1_sel1", sel_r1, 1);
    chk("conf1_bubble", first_r1 - last_r0, 2);

    // Conflict again, rr now favours s1
    clear_mon();
    fork
      send(0, 1'b0, 2, 4'h2, 1, -1, 0);
      send(1, 1'b0, 2, 4'hE, 1, -1, 0);
    join
    settle();
    chk("conf2_first", first_src, 1);
    chk("conf2_sel1", sel_r1, 1);
    chk("conf2_sel0", sel_r0, 0);
    chk("conf2_bubble", first_r0 - last_r1, 2);

    // Granted s1 stalls 2 cycles mid-burst
    clear_mon();
    send(1, 1'b1, 3, 4'hC, 1, 1, 2);
    settle();
    chk("gap_ready_cycles", n_r1, 5);
    chk("gap_o2", n_o2, 3);
    chk("gap_sel", sel_r1, 0);

    // Single-beat burst
    clear_mon();
    send(0, 1'b1, 1, 4'h7, 0, -1, 0);
    settle();
    chk("single_ready_cycles", n_r0, 1);
    chk("single_o2", n_o2, 1);
    chk("single_o1", n_o1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
